// File: rtl/alu_pkg.sv
// Shared constants for the ALU front end: opcode encodings and the
// state type of the operation-valid controller.
package alu_pkg;

    localparam int NUM_KEYS = 4;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One push-key: 2-flop synchronizer, stability counter and debounced level.
// o_press is a one-cycle pulse when the debounced level goes to pressed.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_prev;
    logic [CNT_W-1:0] r_cnt;

    // Everything resets to the released (high) level so a held key is
    // re-debounced from scratch after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_deb      <= 1'b1;
            r_deb_prev <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_key_n;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_deb_prev & ~r_deb;

endmodule

// File: rtl/alu_input_ctrl.sv
// Drives the ALU operands and opcode bits from switches and debounced keys;
// each clean key press toggles its opcode bit and snapshots the switches.
module alu_input_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_n,
    input  logic [WIDTH-1:0] sw_a,
    input  logic [WIDTH-1:0] sw_b,
    input  logic             sw_cin,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    output logic             boton0,
    output logic             boton1,
    output logic             boton2,
    output logic             boton3,
    output logic             op_valid
);

    logic [NUM_KEYS-1:0] w_press;
    logic                w_any_press;
    ctrl_state_t         r_state;
    ctrl_state_t         w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_cin;
    logic [NUM_KEYS-1:0] r_boton;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst    (rst),
                .i_key_n(key_n[gi]),
                .o_press(w_press[gi])
            );
        end
    endgenerate

    assign w_any_press = |w_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        op_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_press) w_state_next = VALID;
            end
            VALID: begin
                op_valid = 1'b1;
                if (!w_any_press) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Simultaneous presses all toggle; switches are sampled only on an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_boton <= OP_NOP;
        end else if (w_any_press) begin
            r_a     <= sw_a;
            r_b     <= sw_b;
            r_cin   <= sw_cin;
            r_boton <= r_boton ^ w_press;
        end
    end

    assign A      = r_a;
    assign B      = r_b;
    assign Cin    = r_cin;
    assign boton0 = r_boton[0];
    assign boton1 = r_boton[1];
    assign boton2 = r_boton[2];
    assign boton3 = r_boton[3];

endmodule
